// File: rtl/nv_ram_rws_stream_fifo_pkg.sv
// Shared constants and types for the RAM-backed stream FIFO.
//   FIFO_DW/FIFO_AW/FIFO_DEPTH : default data width, RAM address width, RAM entries
//   SKID_DEPTH                 : entries in the output skid buffer
//   skid_op_e                  : per-cycle skid operation, encoded as {capture, pop}
package nv_fifo_pkg;

   localparam int unsigned FIFO_DW    = 64;
   localparam int unsigned FIFO_AW    = 8;
   localparam int unsigned FIFO_DEPTH = 256;
   localparam int unsigned SKID_DEPTH = 2;

   typedef enum logic [1:0] {
      SKID_HOLD = 2'b00,
      SKID_POP  = 2'b01,
      SKID_CAP  = 2'b10,
      SKID_BOTH = 2'b11
   } skid_op_e;

endpackage

// File: rtl/nv_ram_rws_stream_fifo_if.sv
// Write/read valid-ready stream bundle of the FIFO.
//   wr_pvld/wr_prdy/wr_pd : producer -> FIFO write stream
//   rd_pvld/rd_prdy/rd_pd : FIFO -> consumer read stream
//   modport slave  : FIFO side
//   modport master : producer/consumer side
interface nv_ram_rws_stream_fifo_if
   import nv_fifo_pkg::*;
#(
   parameter int unsigned DW = FIFO_DW
);
   logic          wr_pvld;
   logic          wr_prdy;
   logic [DW-1:0] wr_pd;
   logic          rd_pvld;
   logic          rd_prdy;
   logic [DW-1:0] rd_pd;

   modport slave  (input  wr_pvld, wr_pd, rd_prdy,
                   output wr_prdy, rd_pvld, rd_pd);
   modport master (output wr_pvld, wr_pd, rd_prdy,
                   input  wr_prdy, rd_pvld, rd_pd);
endinterface

// File: rtl/nv_ram_rws_stream_fifo_skid2.sv
// Two-entry in-order skid buffer holding RAM read data ahead of the consumer.
//   clk, rst_n       : clock, asynchronous active-low reset
//   cap_vld, cap_pd  : capture a beat into the tail
//   pop              : consumer takes the head this cycle
//   head_vld, head_pd: head entry (registered)
//   cnt              : entries held (0..2)
module nv_fifo_skid2
   import nv_fifo_pkg::*;
#(
   parameter int unsigned DW = FIFO_DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cap_vld,
   input  logic [DW-1:0] cap_pd,
   input  logic          pop,
   output logic          head_vld,
   output logic [DW-1:0] head_pd,
   output logic [1:0]    cnt
);
   logic [DW-1:0] ent0;
   logic [DW-1:0] ent1;
   logic [1:0]    cnt_q;
   skid_op_e      op;

   always_comb op = skid_op_e'({cap_vld, pop});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         ent0  <= '0;
         ent1  <= '0;
      end else begin
         case (op)
            SKID_CAP: begin
               if (cnt_q == 2'd0) ent0 <= cap_pd;
               else               ent1 <= cap_pd;
               cnt_q <= cnt_q + 2'd1;
            end
            SKID_POP: begin
               ent0  <= ent1;
               cnt_q <= cnt_q - 2'd1;
            end
            SKID_BOTH: begin
               // Occupancy unchanged: the new beat lands behind whatever remains.
               if (cnt_q == 2'd2) begin
                  ent0 <= ent1;
                  ent1 <= cap_pd;
               end else begin
                  ent0 <= cap_pd;
               end
            end
            default: ;
         endcase
      end
   end

   assign head_vld = (cnt_q != 2'd0);
   assign head_pd  = ent0;
   assign cnt      = cnt_q;
endmodule

// File: rtl/nv_ram_rws_stream_fifo.sv
// Streaming FIFO controller driving an external 1R1W RAM with registered read.
//   nvdla_core_clk, nvdla_core_rstn : clock, asynchronous active-low reset
//   strm (slave)                    : write and read valid/ready streams
//   ram_we/ram_wa/ram_di            : RAM write port
//   ram_re/ram_ra/ram_dout          : RAM read port, dout valid the cycle after re
//   fifo_count                      : entries held in RAM + in flight + skid
//   pwrbus_ram_pd -> ram_pwrbus_pd  : RAM power-down bus passthrough
module nv_ram_rws_stream_fifo
   import nv_fifo_pkg::*;
#(
   parameter int unsigned DW    = FIFO_DW,
   parameter int unsigned AW    = FIFO_AW,
   parameter int unsigned DEPTH = FIFO_DEPTH
) (
   input  logic                     nvdla_core_clk,
   input  logic                     nvdla_core_rstn,
   nv_ram_rws_stream_fifo_if.slave  strm,
   output logic                     ram_we,
   output logic [AW-1:0]            ram_wa,
   output logic [DW-1:0]            ram_di,
   output logic                     ram_re,
   output logic [AW-1:0]            ram_ra,
   input  logic [DW-1:0]            ram_dout,
   output logic [AW:0]              fifo_count,
   input  logic [31:0]              pwrbus_ram_pd,
   output logic [31:0]              ram_pwrbus_pd
);
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   ram_cnt;
   logic          inflight;
   logic [1:0]    skid_cnt;
   logic [2:0]    occ;
   logic          push;
   logic          pop;
   logic          issue;

   assign strm.wr_prdy = (ram_cnt != (AW+1)'(DEPTH));
   assign push         = strm.wr_pvld & strm.wr_prdy;
   assign pop          = strm.rd_pvld & strm.rd_prdy;

   // Issue only if the beat is guaranteed a skid slot when it returns;
   // "occ - pop < SKID_DEPTH" rewritten to avoid unsigned underflow.
   assign occ   = 3'(skid_cnt) + 3'(inflight);
   assign issue = (ram_cnt != '0) && (occ < 3'(SKID_DEPTH) + 3'(pop));

   assign ram_we        = push;
   assign ram_wa        = wr_ptr;
   assign ram_di        = strm.wr_pd;
   assign ram_re        = issue;
   assign ram_ra        = rd_ptr;
   assign ram_pwrbus_pd = pwrbus_ram_pd;

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         ram_cnt    <= '0;
         inflight   <= 1'b0;
         fifo_count <= '0;
      end else begin
         if (push)  wr_ptr <= wr_ptr + 1'b1;
         if (issue) rd_ptr <= rd_ptr + 1'b1;
         inflight <= issue;
         case ({push, issue})
            2'b10:   ram_cnt <= ram_cnt + 1'b1;
            2'b01:   ram_cnt <= ram_cnt - 1'b1;
            default: ;
         endcase
         // Running push-pop total equals ram_cnt + inflight + skid_cnt.
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: ;
         endcase
      end
   end

   nv_fifo_skid2 #(.DW(DW)) u_skid (
      .clk      (nvdla_core_clk),
      .rst_n    (nvdla_core_rstn),
      .cap_vld  (inflight),
      .cap_pd   (ram_dout),
      .pop      (pop),
      .head_vld (strm.rd_pvld),
      .head_pd  (strm.rd_pd),
      .cnt      (skid_cnt)
   );
endmodule

// File: tb/tb_nv_ram_rws_stream_fifo.sv
// Directed + randomized bench for the RAM-backed stream FIFO. A behavioural RAM
// sits beside the DUT; a queue scoreboard holds the expected FIFO contents.
module tb_nv_ram_rws_stream_fifo;
   logic        clk = 1'b0;
   logic        rstn;
   logic        ram_we, ram_re;
   logic [7:0]  ram_wa, ram_ra;
   logic [63:0] ram_di, ram_dout;
   logic [8:0]  fifo_count;
   logic [31:0] pwrbus, ram_pwrbus;

   logic [63:0] mem [256];
   logic [63:0] q[$];
   logic [7:0]  model_wa, model_ra;
   logic [63:0] last_pop;
   int          checks = 0, failures = 0;
   int          cyc = 0, npush = 0, npop = 0, wraps = 0;
   int          first_pop_cyc, last_pop_cyc;

   nv_ram_rws_stream_fifo_if #(.DW(64)) sif ();

   nv_ram_rws_stream_fifo #(.DW(64), .AW(8), .DEPTH(256)) dut (
      .nvdla_core_clk  (clk),
      .nvdla_core_rstn (rstn),
      .strm            (sif),
      .ram_we          (ram_we),
      .ram_wa          (ram_wa),
      .ram_di          (ram_di),
      .ram_re          (ram_re),
      .ram_ra          (ram_ra),
      .ram_dout        (ram_dout),
      .fifo_count      (fifo_count),
      .pwrbus_ram_pd   (pwrbus),
      .ram_pwrbus_pd   (ram_pwrbus)
   );

   always #5 clk = ~clk;

   // RAM macro: registered read address, write and read on the same edge.
   always @(posedge clk) begin
      if (ram_we) mem[ram_wa] <= ram_di;
      if (ram_re) ram_dout <= mem[ram_ra];
   end

   function automatic logic [63:0] rand64();
      return {$urandom, $urandom};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at the negedge: check handshake side effects against the model,
   // update the scoreboard, then advance to just after the next posedge.
   task automatic commit();
      logic push, pop;
      logic [63:0] exp;
      push = sif.wr_pvld & sif.wr_prdy;
      pop  = sif.rd_pvld & sif.rd_prdy;
      chk("fifo_count", 64'(fifo_count), 64'(q.size()));
      chk("ram_we", 64'(ram_we), 64'(push));
      if (push) begin
         chk("ram_wa", 64'(ram_wa), 64'(model_wa));
         chk("ram_di", ram_di, sif.wr_pd);
      end
      if (ram_re) begin
         chk("ram_ra", 64'(ram_ra), 64'(model_ra));
         model_ra++;
      end
      if (pop) begin
         if (q.size() == 0) begin
            chk("pop_empty", 64'(sif.rd_pvld), 64'(0));
         end else begin
            exp = q.pop_front();
            chk("rd_pd", sif.rd_pd, exp);
            last_pop = exp;
            npop++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
         end
      end
      if (push) begin
         q.push_back(sif.wr_pd);
         if (ram_wa == 8'hFF) wraps++;
         model_wa++;
         npush++;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int bound);
      sif.wr_pvld = 1'b0;
      sif.rd_prdy = 1'b1;
      for (int i = 0; i < bound && q.size() > 0; i++) begin
         @(negedge clk);
         commit();
      end
      @(negedge clk);
      chk("drain_count", 64'(fifo_count), 64'(0));
      chk("drain_rd_pvld", 64'(sif.rd_pvld), 64'(0));
      commit();
   endtask

   initial begin
      int start, base;
      rstn = 1'b0;
      sif.wr_pvld = 1'b0;
      sif.wr_pd = '0;
      sif.rd_prdy = 1'b0;
      pwrbus = 32'h1234_5678;
      model_wa = '0;
      model_ra = '0;
      first_pop_cyc = -1;
      last_pop_cyc = -1;
      last_pop = '0;

      // Reset values
      #12;
      chk("rst_rd_pvld", 64'(sif.rd_pvld), 64'(0));
      chk("rst_ram_we", 64'(ram_we), 64'(0));
      chk("rst_ram_re", 64'(ram_re), 64'(0));
      chk("rst_fifo_count", 64'(fifo_count), 64'(0));
      chk("pwrbus", 64'(ram_pwrbus), 64'(32'h1234_5678));
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_wr_prdy", 64'(sif.wr_prdy), 64'(1));

      // Single push latency
      sif.wr_pvld = 1'b1;
      sif.wr_pd = 64'hA5;
      sif.rd_prdy = 1'b1;
      @(negedge clk);
      chk("lat_c0_we", 64'(ram_we), 64'(1));
      chk("lat_c0_wa", 64'(ram_wa), 64'(0));
      chk("lat_c0_di", ram_di, 64'hA5);
      chk("lat_c0_re", 64'(ram_re), 64'(0));
      commit();
      sif.wr_pvld = 1'b0;
      @(negedge clk);
      chk("lat_c1_re", 64'(ram_re), 64'(1));
      chk("lat_c1_ra", 64'(ram_ra), 64'(0));
      chk("lat_c1_pvld", 64'(sif.rd_pvld), 64'(0));
      commit();
      @(negedge clk);
      chk("lat_c2_pvld", 64'(sif.rd_pvld), 64'(0));
      commit();
      @(negedge clk);
      chk("lat_c3_pvld", 64'(sif.rd_pvld), 64'(1));
      chk("lat_c3_pd", sif.rd_pd, 64'hA5);
      commit();
      @(negedge clk);
      chk("lat_empty_count", 64'(fifo_count), 64'(0));
      commit();

      // Fill with consumer stalled
      sif.rd_prdy = 1'b0;
      for (int i = 0; i < 400; i++) begin
         sif.wr_pvld = 1'b1;
         sif.wr_pd = rand64();
         @(negedge clk);
         if (!sif.wr_prdy) break;
         commit();
      end
      chk("full_wr_prdy", 64'(sif.wr_prdy), 64'(0));
      chk("full_count", 64'(fifo_count), 64'(258));
      chk("full_rd_pvld", 64'(sif.rd_pvld), 64'(1));
      chk("full_ram_re", 64'(ram_re), 64'(0));
      chk("full_ram_we", 64'(ram_we), 64'(0));
      commit();

      // Full, pop one: slot freed, writable next cycle, new beat comes out last
      sif.wr_pvld = 1'b1;
      sif.wr_pd = 64'hBEEF_0000_CAFE_0001;
      sif.rd_prdy = 1'b1;
      @(negedge clk);
      chk("pop1_wr_prdy", 64'(sif.wr_prdy), 64'(0));
      chk("pop1_ram_re", 64'(ram_re), 64'(1));
      commit();
      sif.rd_prdy = 1'b0;
      @(negedge clk);
      chk("pop1_next_wr_prdy", 64'(sif.wr_prdy), 64'(1));
      chk("pop1_next_we", 64'(ram_we), 64'(1));
      commit();
      drain(600);
      chk("pop1_last_out", last_pop, 64'hBEEF_0000_CAFE_0001);

      // Streaming 1000 beats, both sides always ready
      first_pop_cyc = -1;
      start = cyc;
      base = npop;
      sif.rd_prdy = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         sif.wr_pvld = 1'b1;
         sif.wr_pd = rand64();
         @(negedge clk);
         commit();
      end
      drain(50);
      chk("stream_npop", 64'(npop - base), 64'(1000));
      chk("stream_latency", 64'(first_pop_cyc - start), 64'(3));
      chk("stream_no_bubble", 64'(last_pop_cyc - first_pop_cyc + 1), 64'(1000));

      // Random 50% valid/ready, 10k beats
      wraps = 0;
      base = npush;
      for (int i = 0; i < 60000 && (npush - base) < 10000; i++) begin
         sif.wr_pvld = 1'($urandom_range(0, 1));
         sif.wr_pd = rand64();
         sif.rd_prdy = 1'($urandom_range(0, 1));
         pwrbus = $urandom;
         @(negedge clk);
         if (i % 1000 == 0) chk("pwrbus_rand", 64'(ram_pwrbus), 64'(pwrbus));
         commit();
      end
      drain(600);
      chk("rand_npush", 64'(npush - base), 64'(10000));
      chk("rand_wraps_ge30", 64'(wraps >= 30), 64'(1));

      // Asynchronous reset mid-stream with 100 entries held
      sif.rd_prdy = 1'b0;
      for (int i = 0; i < 100; i++) begin
         sif.wr_pvld = 1'b1;
         sif.wr_pd = rand64();
         @(negedge clk);
         commit();
      end
      sif.wr_pvld = 1'b0;
      @(negedge clk);
      chk("pre_rst_count", 64'(fifo_count), 64'(100));
      commit();
      #2;
      rstn = 1'b0;
      #1;
      chk("mid_rst_rd_pvld", 64'(sif.rd_pvld), 64'(0));
      chk("mid_rst_ram_we", 64'(ram_we), 64'(0));
      chk("mid_rst_ram_re", 64'(ram_re), 64'(0));
      chk("mid_rst_count", 64'(fifo_count), 64'(0));
      chk("mid_rst_wr_prdy", 64'(sif.wr_prdy), 64'(1));
      q.delete();
      model_wa = '0;
      model_ra = '0;
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      sif.rd_prdy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         sif.wr_pvld = 1'b1;
         sif.wr_pd = 64'h100 + 64'(i);
         @(negedge clk);
         commit();
      end
      drain(50);
      chk("post_rst_last", last_pop, 64'h104);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
